reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Sits downstream of the clock/reset generation. Runs in one destination clock domain and consumes that domain's asynchronous "clock ready" indication (MMCM/PLL locked, or the upstream rstn).
- Releases the domain's subsystems from reset in a fixed, staged order, for example memory/framebuffer first, then pipeline, then the display timing generator.
- Re-asserts every stage reset if readiness is lost.
- Reports completion, a sticky startup timeout, and a saturating loss counter for debug.

Parameters:
- NUM_STAGES, 3, number of staged active-low reset outputs (1..8)
- STAGE_DELAY, 16, cycles between successive stage releases; also the hold time and the ready-stability window (>=2)
- READY_TIMEOUT, 1024, cycles spent in WAIT_READY before timeout_err is raised (> STAGE_DELAY)

Ports:
- clk  input  1  domain clock
- reset  input  1  synchronous, active-high reset
- ready_in  input  1  asynchronous readiness flag (locked/rstn from clock generation); 2-FF synchronized internally
- rstn_out  output  NUM_STAGES  active-low stage resets; bit 0 is released first
- done  output  1  high while every stage is released
- timeout_err  output  1  sticky; set if ready is not stable within READY_TIMEOUT
- loss_count  output  8  saturating count of readiness losses after the first full release

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-high, on port reset.
- ready_s is ready_in passed through 2 FFs, so ready_s lags ready_in by 2 cycles. All outputs are registered.
- Reset values: rstn_out = all 0, done = 0, timeout_err = 0, loss_count = 0, FSM = HOLD, counters = 0. Synchronizer FFs reset to 0.
- HOLD:
  - Counts STAGE_DELAY cycles starting with the first cycle after reset deasserts.
  - Moves to WAIT_READY when the count reaches STAGE_DELAY-1.
  - ready_s is ignored.
- WAIT_READY:
  - stable_cnt increments while ready_s=1 and clears to 0 when ready_s=0.
  - Moves to RELEASE on the cycle stable_cnt reaches STAGE_DELAY-1 with ready_s=1.
  - A timeout counter runs from entry into WAIT_READY. At READY_TIMEOUT cycles, timeout_err is set (sticky until reset) and the FSM stays in WAIT_READY, still waiting.
  - The timeout counter saturates and does not wrap.
- RELEASE:
  - rel_cnt counts from 0 on entry.
  - Stage i deasserts (rstn_out[i] becomes 1) when rel_cnt reaches (i+1)*STAGE_DELAY-1; the output is visible the next cycle.
  - Once released, a stage stays released.
  - After the last stage releases, the FSM moves to RUN and done=1 in the same cycle that rstn_out[NUM_STAGES-1] rises.
- RUN: holds all rstn_out=1 and done=1.
- Readiness loss:
  - Applies when ready_s=0 in RELEASE or RUN.
  - Next cycle: rstn_out = all 0, done=0, FSM = HOLD, all counters cleared.
  - loss_count increments (saturating at 255) only if the loss happens in RUN.
  - timeout_err is unaffected.
- rstn_out is never released out of order. rstn_out[j]=1 implies rstn_out[i]=1 for all i<j.
- reset asserted in any state: next cycle all reset values, including timeout_err and loss_count.
- A ready_in glitch shorter than STAGE_DELAY cycles during WAIT_READY restarts the stability window and never causes a release.

Test Plan:
- Nominal start: NUM_STAGES=3, STAGE_DELAY=4, ready_in=1 throughout, reset 1->0 at cycle 0.
  - rstn_out[0] rises at cycle 12, rstn_out[1] at 16, rstn_out[2] at 20.
  - done=1 at 20, rstn_out = 3'b111.
- Glitch rejection: in WAIT_READY, ready_in pulses 1 for 2 cycles, then 0, then 1 steady.
  - No stage releases until 4 consecutive ready_s=1 cycles; the release timeline restarts from there.
- Timeout: READY_TIMEOUT=32, ready_in=0.
  - timeout_err=1 exactly 32 cycles after entering WAIT_READY; rstn_out stays 0.
  - Raising ready_in later still completes the sequence with timeout_err held at 1.
- Loss in RUN: after done=1, drop ready_in for 1 cycle.
  - 3 cycles later rstn_out=0, done=0, loss_count=1.
  - Full sequence repeats and done returns 1.
- Loss mid-RELEASE: drop ready_in after rstn_out[0] releases.
  - All stages reassert, loss_count stays 0, restart from HOLD.
- Synchronous reset mid-RUN with loss_count=5, timeout_err=1: assert reset for 1 cycle.
  - Next cycle all outputs are 0.
  - Saturation check: 300 losses leave loss_count=255.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset release for one clock domain: waits for a stable "clock ready",
// then releases NUM_STAGES active-low resets in order, re-asserting all on loss.
module reset_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int STAGE_DELAY   = 16,
    parameter int READY_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready_in,
    output logic [NUM_STAGES-1:0] rstn_out,
    output logic                  done,
    output logic                  timeout_err,
    output logic [7:0]            loss_count
);

    localparam int CNT_W = $clog2(STAGE_DELAY);
    localparam int TMO_W = $clog2(READY_TIMEOUT);
    localparam int REL_W = $clog2(NUM_STAGES * STAGE_DELAY);

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(READY_TIMEOUT - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(NUM_STAGES * STAGE_DELAY - 1);

    typedef enum logic [1:0] {
        HOLD,
        WAIT_READY,
        RELEASE,
        RUN
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              sync_q;
    logic [CNT_W-1:0]        hold_q, hold_d;
    logic [CNT_W-1:0]        stable_q, stable_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [REL_W-1:0]        rel_q, rel_d;
    logic [NUM_STAGES-1:0]   rstn_q, rstn_d;
    logic                    done_q, done_d;
    logic                    timeout_q, timeout_d;
    logic [7:0]              loss_q, loss_d;
    logic                    ready_s;

    assign ready_s = sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HOLD;
            sync_q    <= '0;
            hold_q    <= '0;
            stable_q  <= '0;
            tmo_q     <= '0;
            rel_q     <= '0;
            rstn_q    <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], ready_in};
            hold_q    <= hold_d;
            stable_q  <= stable_d;
            tmo_q     <= tmo_d;
            rel_q     <= rel_d;
            rstn_q    <= rstn_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            loss_q    <= loss_d;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        stable_d  = stable_q;
        tmo_d     = tmo_q;
        rel_d     = rel_q;
        rstn_d    = rstn_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        loss_d    = loss_q;

        unique case (state_q)
            HOLD: begin
                if (hold_q == DLY_LAST) begin
                    state_d  = WAIT_READY;
                    hold_d   = '0;
                    stable_d = '0;
                    tmo_d    = '0;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end

            WAIT_READY: begin
                // Timeout counter parks at its last value so the flag stays set
                // without the counter wrapping.
                if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end

                if (!ready_s) begin
                    stable_d = '0;
                end else if (stable_q == DLY_LAST) begin
                    state_d  = RELEASE;
                    stable_d = '0;
                    rel_d    = '0;
                end else begin
                    stable_d = stable_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (!ready_s) begin
                    state_d  = HOLD;
                    hold_d   = '0;
                    stable_d = '0;
                    tmo_d    = '0;
                    rel_d    = '0;
                    rstn_d   = '0;
                    done_d   = 1'b0;
                end else begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (rel_q == REL_W'((i + 1) * STAGE_DELAY - 1)) begin
                            rstn_d[i] = 1'b1;
                        end
                    end
                    if (rel_q == REL_LAST) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        rel_d = rel_q + REL_W'(1);
                    end
                end
            end

            RUN: begin
                if (!ready_s) begin
                    state_d  = HOLD;
                    hold_d   = '0;
                    stable_d = '0;
                    tmo_d    = '0;
                    rel_d    = '0;
                    rstn_d   = '0;
                    done_d   = 1'b0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end

            default: state_d = HOLD;
        endcase
    end

    assign rstn_out    = rstn_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign loss_count  = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected output snapshots are queued with
// their due cycle and compared when the simulation reaches that cycle.
module tb_reset_sequencer;

    localparam int NS = 3;
    localparam int SD = 4;
    localparam int RT = 32;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          ready_in = 1'b0;
    logic [NS-1:0] rstn_out;
    logic          done;
    logic          timeout_err;
    logic [7:0]    loss_count;

    reset_sequencer #(
        .NUM_STAGES   (NS),
        .STAGE_DELAY  (SD),
        .READY_TIMEOUT(RT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ready_in   (ready_in),
        .rstn_out   (rstn_out),
        .done       (done),
        .timeout_err(timeout_err),
        .loss_count (loss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            at;
        string         tag;
        logic [NS-1:0] rstn;
        logic          done;
        logic          tmo;
        logic [7:0]    loss;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   base     = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic expect_abs(input int at, input string tag, input logic [NS-1:0] r,
                              input logic d, input logic t, input logic [7:0] l);
        exp_t e;
        e.at   = at;
        e.tag  = tag;
        e.rstn = r;
        e.done = d;
        e.tmo  = t;
        e.loss = l;
        exp_q.push_back(e);
    endtask

    task automatic expect_rel(input int rel, input string tag, input logic [NS-1:0] r,
                              input logic d, input logic t, input logic [7:0] l);
        expect_abs(base + rel, tag, r, d, t, l);
    endtask

    task automatic check_due();
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            assert ({rstn_out, done, timeout_err, loss_count} === {e.rstn, e.done, e.tmo, e.loss})
                n_pass++;
            else
                $error("FAIL %s @cycle %0d: got rstn=%b done=%b tmo=%b loss=%0d, want rstn=%b done=%b tmo=%b loss=%0d",
                       e.tag, cyc - base, rstn_out, done, timeout_err, loss_count,
                       e.rstn, e.done, e.tmo, e.loss);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        n_checks++;
        assert ((rstn_out & (rstn_out + NS'(1))) === '0) n_pass++;
        else $error("FAIL stage_order @%0d: got rstn=%b, want thermometer code", cyc, rstn_out);
        n_checks++;
        assert (done === &rstn_out) n_pass++;
        else $error("FAIL done_vs_rstn @%0d: got done=%b, want %b", cyc, done, &rstn_out);
        check_due();
    endtask

    task automatic run_to(input int rel);
        check_due();
        while (cyc < base + rel) step();
    endtask

    task automatic do_reset(input logic rdy);
        ready_in = rdy;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        base     = cyc;
    endtask

    // Called while in RUN: one-cycle ready drop, zeros 3 cycles later, done again
    // a full 20-cycle sequence after that.
    task automatic lose_in_run(input string tag, input logic [7:0] loss_exp, input logic tmo_exp);
        expect_abs(cyc + 3,  {tag, "_drop"},   3'b000, 1'b0, tmo_exp, loss_exp);
        expect_abs(cyc + 23, {tag, "_redone"}, 3'b111, 1'b1, tmo_exp, loss_exp);
        ready_in = 1'b0;
        step();
        ready_in = 1'b1;
        repeat (22) step();
    endtask

    initial begin
        exp_t e;

        // Nominal start, then a loss in RUN.
        do_reset(1'b1);
        expect_rel(0,  "reset_state",     3'b000, 1'b0, 1'b0, 8'd0);
        expect_rel(11, "nom_pre_s0",      3'b000, 1'b0, 1'b0, 8'd0);
        expect_rel(12, "nom_s0",          3'b001, 1'b0, 1'b0, 8'd0);
        expect_rel(15, "nom_pre_s1",      3'b001, 1'b0, 1'b0, 8'd0);
        expect_rel(16, "nom_s1",          3'b011, 1'b0, 1'b0, 8'd0);
        expect_rel(19, "nom_pre_done",    3'b011, 1'b0, 1'b0, 8'd0);
        expect_rel(20, "nom_done",        3'b111, 1'b1, 1'b0, 8'd0);
        expect_rel(26, "run_before_loss", 3'b111, 1'b1, 1'b0, 8'd0);
        run_to(24);
        lose_in_run("run_loss", 8'd1, 1'b0);

        // Loss mid-RELEASE after stage 0 is out of reset.
        do_reset(1'b1);
        expect_rel(12, "mid_s0",       3'b001, 1'b0, 1'b0, 8'd0);
        expect_rel(14, "mid_pre_loss", 3'b001, 1'b0, 1'b0, 8'd0);
        expect_rel(15, "mid_loss",     3'b000, 1'b0, 1'b0, 8'd0);
        expect_rel(26, "mid_re_pre",   3'b000, 1'b0, 1'b0, 8'd0);
        expect_rel(27, "mid_re_s0",    3'b001, 1'b0, 1'b0, 8'd0);
        expect_rel(35, "mid_re_done",  3'b111, 1'b1, 1'b0, 8'd0);
        run_to(12);
        ready_in = 1'b0;
        run_to(13);
        ready_in = 1'b1;
        run_to(35);

        // Glitch rejection: 2-cycle pulse in WAIT_READY, then steady ready.
        do_reset(1'b0);
        expect_rel(14, "glitch_no_rel",  3'b000, 1'b0, 1'b0, 8'd0);
        expect_rel(18, "glitch_pre_s0",  3'b000, 1'b0, 1'b0, 8'd0);
        expect_rel(19, "glitch_s0",      3'b001, 1'b0, 1'b0, 8'd0);
        expect_rel(27, "glitch_done",    3'b111, 1'b1, 1'b0, 8'd0);
        run_to(6);
        ready_in = 1'b1;
        run_to(8);
        ready_in = 1'b0;
        run_to(9);
        ready_in = 1'b1;
        run_to(27);

        // Timeout with ready low, late recovery keeps the sticky flag.
        do_reset(1'b0);
        expect_rel(35, "tmo_pre",      3'b000, 1'b0, 1'b0, 8'd0);
        expect_rel(36, "tmo_set",      3'b000, 1'b0, 1'b1, 8'd0);
        expect_rel(50, "tmo_held",     3'b000, 1'b0, 1'b1, 8'd0);
        expect_rel(59, "tmo_pre_s0",   3'b000, 1'b0, 1'b1, 8'd0);
        expect_rel(60, "tmo_s0",       3'b001, 1'b0, 1'b1, 8'd0);
        expect_rel(68, "tmo_done",     3'b111, 1'b1, 1'b1, 8'd0);
        run_to(50);
        ready_in = 1'b1;
        run_to(68);
        for (int k = 1; k <= 5; k++) lose_in_run("tmo_loss", 8'(k), 1'b1);

        // Synchronous reset mid-RUN clears the sticky flag and the loss counter.
        expect_abs(cyc + 1, "sync_reset", 3'b000, 1'b0, 1'b0, 8'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        base  = cyc;
        expect_rel(20, "post_reset_done", 3'b111, 1'b1, 1'b0, 8'd0);
        run_to(20);

        // Saturation of the loss counter.
        for (int k = 1; k <= 300; k++) lose_in_run("sat", 8'((k > 255) ? 255 : k), 1'b0);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            $error("FAIL %s: due at cycle %0d, never reached (now %0d)", e.tag, e.at, cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
